// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and types for the fetch path
package cpu_pkg;

  localparam int INSTR_W        = 19;
  localparam int DEFAULT_ADDR_W = 12;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] pc;
    instr_t                    instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch FIFO with flush; flush wins over push and pop
module fetch_fifo #(
  parameter int W     = 31,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + AW'(1);
      if (pop_i)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push_i && !flush_i) mem_q[wptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC, in-order imem requests and prefetch buffer feeding the controller
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter int                DEPTH    = 4,
  parameter int                MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  instr_t            imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  output instr_t            instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int CW = 2;
  localparam int FW = ADDR_W + INSTR_W;
  localparam int NW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0]     out_cnt_q, out_cnt_d, disc_cnt_q, disc_cnt_d;
  logic [NW-1:0]     fifo_count;
  logic [FW-1:0]     fifo_head;
  logic              fifo_empty, fifo_push, fifo_pop, grant, rv_acc;

  // Kept in-flight responses plus buffered words never exceed DEPTH, so a push always has room.
  assign imem_req = reset_n & ~redirect & (int'(out_cnt_q) < MAX_OUT)
                  & ((int'(out_cnt_q) - int'(disc_cnt_q) + int'(fifo_count)) < DEPTH);
  assign grant    = imem_req & imem_gnt;
  assign rv_acc   = imem_rvalid & (out_cnt_q != '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    out_cnt_d  = out_cnt_q;
    disc_cnt_d = disc_cnt_q;
    fifo_push  = 1'b0;
    if (redirect) begin
      fetch_pc_d = redirect_addr;
      resp_pc_d  = redirect_addr;
      out_cnt_d  = out_cnt_q - CW'(rv_acc);
      disc_cnt_d = out_cnt_d;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      out_cnt_d = out_cnt_q + CW'(grant) - CW'(rv_acc);
      if (rv_acc) begin
        if (disc_cnt_q != '0) begin
          disc_cnt_d = disc_cnt_q - CW'(1);
        end else begin
          fifo_push = 1'b1;
          resp_pc_d = resp_pc_q + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
    end
  end

  assign instr_valid = ~fifo_empty & ~redirect;
  assign fifo_pop    = instr_valid & instr_ready;

  fetch_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush_i (redirect),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  ({resp_pc_q, imem_rdata}),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign imem_addr = fetch_pc_q;
  assign instr_pc  = fifo_head[FW-1:INSTR_W];
  assign instr     = fifo_head[INSTR_W-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and randomized checks of instr_fetch against a stream model
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int             AW      = 12;
  localparam int             DEPTH   = 4;
  localparam int             MAX_OUT = 2;
  localparam logic [AW-1:0]  RPC     = 12'h000;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          imem_req, instr_valid;
  logic          imem_gnt = 1'b0, imem_rvalid = 1'b0, redirect = 1'b0, instr_ready = 1'b0;
  logic [AW-1:0] imem_addr, instr_pc;
  logic [AW-1:0] redirect_addr = '0;
  instr_t        imem_rdata = '0;
  instr_t        instr;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  instr_fetch #(.ADDR_W(AW), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RPC)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  function automatic instr_t mem_word(input logic [AW-1:0] a);
    return {a[6:0] ^ 7'h2B, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model and expected-stream model. Epochs separate kept responses from discarded ones.
  typedef struct { logic [AW-1:0] addr; int epoch; int gcyc; } req_t;
  req_t          pend[$];
  logic [AW-1:0] dlog[$];
  int            cyc = 0, epoch = 0, g = 0, k = 0, d = 0;
  int            gnt_mode = 1, rv_pct = 100, lat = 1;
  bit            stray_req = 1'b0;
  logic [AW-1:0] exp_fetch = RPC, exp_out = RPC;

  always @(negedge clock) begin
    req_t r;
    if (!reset_n) begin
      pend.delete();
      epoch++;
      g = 0; k = 0; d = 0;
      exp_fetch = RPC; exp_out = RPC;
    end else begin
      chk("imem_req", 32'(imem_req),
          32'(!redirect && pend.size() < MAX_OUT && (g - d) < DEPTH));
      chk("instr_valid", 32'(instr_valid), 32'(!redirect && (k - d) > 0));
      if (redirect) begin
        epoch++;
        g = 0; k = 0; d = 0;
        exp_fetch = redirect_addr; exp_out = redirect_addr;
      end else if (instr_valid && instr_ready) begin
        chk("instr_pc", 32'(instr_pc), 32'(exp_out));
        chk("instr", 32'(instr), 32'(mem_word(exp_out)));
        dlog.push_back(instr_pc);
        exp_out++; d++;
      end
      if (imem_rvalid && pend.size() > 0) begin
        if (pend[0].epoch == epoch) k++;
        void'(pend.pop_front());
      end
      if (imem_req && imem_gnt) begin
        chk("imem_addr", 32'(imem_addr), 32'(exp_fetch));
        r.addr = imem_addr; r.epoch = epoch; r.gcyc = cyc;
        pend.push_back(r);
        exp_fetch++; g++;
      end
    end
  end

  always @(posedge clock) begin
    #1;
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = instr_t'($urandom);
    if (stray_req) begin
      imem_rvalid = 1'b1;
      stray_req   = 1'b0;
    end else if (reset_n && pend.size() > 0 && (cyc - pend[0].gcyc) >= lat
                 && $urandom_range(0, 99) < rv_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
    end
    case (gnt_mode)
      0:       imem_gnt = 1'b0;
      1:       imem_gnt = 1'b1;
      default: imem_gnt = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic wait_dlog(input int n, input int budget, input string tag);
    int t = 0;
    while (dlog.size() < n && t < budget) begin
      step();
      t++;
    end
    chk(tag, 32'(dlog.size() >= n), 32'(1));
  endtask

  task automatic chk_seq(input string tag, input logic [AW-1:0] base, input int n);
    for (int i = 0; i < n; i++)
      if (i < dlog.size()) chk(tag, 32'(dlog[i]), 32'(AW'(base + AW'(i))));
  endtask

  initial begin
    logic [AW-1:0] hold_addr;
    int t;

    // Reset values, first-fetch latency and sustained rate
    reset_n = 1'b0; instr_ready = 1'b1;
    step(2);
    chk("rst_req", 32'(imem_req), 32'(0));
    chk("rst_addr", 32'(imem_addr), 32'(RPC));
    chk("rst_valid", 32'(instr_valid), 32'(0));
    chk("rst_instr", 32'(instr), 32'(0));
    chk("rst_pc", 32'(instr_pc), 32'(0));
    reset_n = 1'b1;
    #1;
    chk("c1_req", 32'(imem_req), 32'(1));
    chk("c1_valid", 32'(instr_valid), 32'(0));
    step();
    chk("c2_valid", 32'(instr_valid), 32'(0));
    step();
    chk("c3_valid", 32'(instr_valid), 32'(1));
    chk("c3_pc", 32'(instr_pc), 32'(0));
    chk("c3_instr", 32'(instr), 32'(mem_word(12'h000)));
    dlog.delete();
    step(20);
    chk("throughput", 32'(dlog.size()), 32'(20));

    // Backpressure from reset: buffer fills, fetch stops, then drains in order
    reset_n = 1'b0; instr_ready = 1'b0;
    step();
    reset_n = 1'b1;
    step(12);
    chk("bp_req", 32'(imem_req), 32'(0));
    chk("bp_valid", 32'(instr_valid), 32'(1));
    chk("bp_outstanding", 32'(pend.size()), 32'(0));
    chk("bp_fill", 32'(g - d), 32'(DEPTH));
    chk("bp_head", 32'(instr_pc), 32'(0));
    dlog.delete();
    instr_ready = 1'b1;
    wait_dlog(6, 30, "bp_drain");
    chk_seq("bp_order", 12'h000, 6);

    // Redirect with two requests in flight on a 2-cycle memory
    lat = 2;
    t = 0;
    while (pend.size() != 2 && t < 20) begin step(); t++; end
    chk("rd_inflight", 32'(pend.size()), 32'(2));
    dlog.delete();
    redirect = 1'b1; redirect_addr = 12'h100;
    #1;
    chk("rd_req", 32'(imem_req), 32'(0));
    chk("rd_valid", 32'(instr_valid), 32'(0));
    step();
    redirect = 1'b0;
    wait_dlog(3, 30, "rd_deliv");
    chk_seq("rd_stream", 12'h100, 3);

    // Redirect colliding with rvalid, then a second redirect on the next cycle
    lat = 1;
    t = 0;
    while (imem_rvalid !== 1'b1 && t < 20) begin step(); t++; end
    chk("col_rvalid", 32'(imem_rvalid), 32'(1));
    dlog.delete();
    redirect = 1'b1; redirect_addr = 12'h200;
    step();
    redirect_addr = 12'h300;
    step();
    redirect = 1'b0;
    wait_dlog(4, 30, "col_deliv");
    chk_seq("col_stream", 12'h300, 4);
    dlog.delete();
    step(10);
    chk("col_rate", 32'(dlog.size()), 32'(10));

    // Address wrap
    dlog.delete();
    redirect = 1'b1; redirect_addr = 12'hFFE;
    step();
    redirect = 1'b0;
    wait_dlog(4, 30, "wrap_deliv");
    chk_seq("wrap_stream", 12'hFFE, 4);

    // Grant stall holds the address
    gnt_mode = 0;
    step();
    hold_addr = imem_addr;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_addr", 32'(imem_addr), 32'(hold_addr));
    end
    chk("stall_req", 32'(imem_req), 32'(1));
    gnt_mode = 1;
    step(3);

    // Mid-stream reset, with a stray response right at release
    reset_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(instr_valid), 32'(0));
    chk("mrst_req", 32'(imem_req), 32'(0));
    chk("mrst_addr", 32'(imem_addr), 32'(RPC));
    chk("mrst_instr", 32'(instr), 32'(0));
    chk("mrst_pc", 32'(instr_pc), 32'(0));
    step();
    stray_req = 1'b1;
    dlog.delete();
    step();
    reset_n = 1'b1;
    wait_dlog(3, 30, "mrst_deliv");
    chk_seq("mrst_stream", RPC, 3);

    // Randomized traffic: grants, latency, backpressure and redirect bursts
    gnt_mode = 2;
    for (int it = 0; it < 1500; it++) begin
      if (it % 250 == 0) begin
        lat    = int'($urandom_range(1, 3));
        rv_pct = int'($urandom_range(30, 100));
      end
      instr_ready = ($urandom_range(0, 3) != 0);
      if (redirect) redirect = ($urandom_range(0, 2) == 0);
      else          redirect = ($urandom_range(0, 39) == 0);
      redirect_addr = AW'($urandom);
      step();
    end
    redirect = 1'b0;
    instr_ready = 1'b1;
    gnt_mode = 1; lat = 1; rv_pct = 100;
    dlog.delete();
    wait_dlog(8, 40, "final_deliv");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly upstream of `controller`. It holds the program counter and issues in-order read requests to instruction memory. Returned 19-bit words are buffered in a small prefetch FIFO and presented on a valid/ready port whose `instr` output drives the controller's `allBits`. Redirects from branch/jump resolution flush the buffer and discard in-flight responses.

## Interface

**Parameters**
- `ADDR_W`, 12: instruction address width. Word addressed, one 19-bit word per address.
- `INSTR_W`, 19: instruction width. Fixed by the ISA; taken from the package.
- `DEPTH`, 4: prefetch FIFO entries. Must be a power of two and ≥ 2.
- `MAX_OUT`, 2: maximum outstanding memory requests. Range 1..3.
- `RESET_PC`, 0: first fetch address after reset.

**Ports**
- `clock`, in, 1: single clock. All state updates on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `imem_req`, out, 1: read request valid.
- `imem_addr`, out, ADDR_W: read address, equal to `fetch_pc`.
- `imem_gnt`, in, 1: memory accepts the request this cycle. Only meaningful when `imem_req`=1.
- `imem_rvalid`, in, 1: read data valid. Responses return in order, ≥1 cycle after grant.
- `imem_rdata`, in, INSTR_W: read data.
- `redirect`, in, 1: flush and restart fetch at `redirect_addr`.
- `redirect_addr`, in, ADDR_W: new fetch address.
- `instr_valid`, out, 1: FIFO head valid.
- `instr`, out, INSTR_W: FIFO head instruction. Feeds `controller.allBits`.
- `instr_pc`, out, ADDR_W: address of `instr`.
- `instr_ready`, in, 1: consumer takes the head this cycle.

## Operation

**State**
- `fetch_pc`: next address to request.
- `resp_pc`: address of the next kept response.
- `out_cnt`: 0..MAX_OUT, outstanding requests.
- `disc_cnt`: 0..out_cnt, outstanding responses still to be discarded.
- FIFO of {pc, instr} entries.

**Issue**
- `imem_req` = ~redirect & (out_cnt < MAX_OUT) & ((out_cnt − disc_cnt) + fifo_count < DEPTH).
- Every kept response therefore has a reserved FIFO slot. No overflow is possible.
- On `imem_req & imem_gnt`: `fetch_pc` ← fetch_pc+1 (mod 2^ADDR_W, wraps silently) and `out_cnt` increments.

**Response**
- On `imem_rvalid` with `out_cnt`=0: protocol error. Ignored, no state change.
- On `imem_rvalid` with `disc_cnt`>0: data dropped, `disc_cnt` and `out_cnt` decrement.
- Otherwise: push {resp_pc, imem_rdata}, `resp_pc`+1 (wraps), `out_cnt` decrements.
- A grant and a response in the same cycle leave `out_cnt` unchanged.

**Output handshake**
- `instr_valid` = ~fifo_empty & ~redirect.
- Transfer occurs when `instr_valid & instr_ready`; the head is popped at that edge.
- `instr` and `instr_pc` hold stable while valid and not accepted.
- Push and pop in the same cycle are both legal, including when FIFO count = DEPTH−1.

**Redirect** (takes priority over everything)
- FIFO flushed.
- `fetch_pc` ← `redirect_addr` and `resp_pc` ← `redirect_addr`.
- No request issued, no output transfer.
- Any response arriving in that cycle is dropped.
- `out_cnt` ← out_cnt − rvalid (only when out_cnt > 0).
- `disc_cnt` ← that same new `out_cnt`.
- Redirects on back-to-back cycles are legal; each one recomputes `disc_cnt`.

## Timing

**Reset values**
- `imem_req`: 0 while `reset_n`=0.
- `imem_addr`: RESET_PC.
- `instr_valid`: 0.
- `instr`, `instr_pc`: 0.
- Counters: 0.
- Reset asserted mid-operation clears everything immediately. Responses arriving after reset release with `out_cnt`=0 are ignored.

**Latency and throughput**
- `imem_req` rises in the first cycle after `reset_n` deasserts.
- With grant in cycle t and rvalid in t+1, `instr_valid` is 1 in t+2 (registered FIFO, no bypass).
- With defaults, single-cycle memory and `instr_ready`=1, sustained throughput is 1 instr/cycle.
- After a redirect in cycle r, the first request goes to `redirect_addr` in r+1.

## Structure

- Shared package `cpu_pkg` holds:
  - `INSTR_W`=19 and default `ADDR_W`.
  - Typedef `instr_t` = logic[INSTR_W-1:0].
  - Typedef `fetch_entry_t` = {pc, instr}.
- One sub-module, `fetch_fifo`:
  - Synchronous FIFO, DEPTH entries, push/pop/flush.
  - Outputs count, empty and head.
  - Flush has priority over push and pop.
- Counters and PCs live in `instr_fetch`.

## Test plan

- **Reset and fill.** Reset, memory with gnt=1 and 1-cycle latency, mem[a]=a, ready=1 → instr/instr_pc = 0,1,2,… on consecutive cycles from cycle 3.
- **Backpressure.** ready=0 → FIFO fills to 4, `imem_req` drops, `out_cnt` reaches 0. Raise ready → instructions 0..3 delivered in order, then fetch resumes at 4.
- **Redirect with responses in flight.** 2-cycle memory, redirect to 0x100 with 2 requests outstanding → both old responses dropped. First delivered instr_pc=0x100, no stale words.
- **Redirect collisions.** Redirect in the same cycle as rvalid, and on two back-to-back cycles (0x200, then 0x300) → only the 0x300 stream is delivered, and `disc_cnt` returns to 0.
- **Wrap-around.** RESET_PC=0xFFE, ADDR_W=12 → instr_pc sequence 0xFFE, 0xFFF, 0x000, 0x001.
- **Grant stall and mid-stream reset.** gnt=0 for 5 cycles, then `reset_n` pulsed low mid-stream → `imem_addr` held constant during the stall. On reset, outputs clear immediately and fetch restarts at RESET_PC.
